hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It tracks the destination register and write-back source of the instructions in EX and MEM, and generates the seven hazard flags consumed by the ID-stage operand forwarding/branch unit. It also sequences stalls and bubbles for load-use hazards and for multi-cycle divides occupying EX. Sits beside the ID stage; drives the IF/ID, ID/EX and EX/MEM pipeline-register enables and clears.

---
 rtl/hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: tracks EX/MEM destinations,
// raises forwarding/load-use flags for ID and sequences load-use and divide stalls.
module hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_rf_we,
    input  logic [4:0] id_rf_waddr,
    input  logic [2:0] id_rf_wsel,
    input  logic       id_is_div,
    output logic       id_ex_hazard_mem,
    output logic       id_ex_rs_hazard_reg,
    output logic       id_ex_rt_hazard_reg,
    output logic       id_mem_rs_hazard_mem,
    output logic       id_mem_rs_hazard_reg,
    output logic       id_mem_rt_hazard_mem,
    output logic       id_mem_rt_hazard_reg,
    output logic [2:0] ex_rf_wsel,
    output logic [2:0] mem_rf_wsel,
    output logic       stall_if,
    output logic       bubble_ex,
    output logic       stall_ex,
    output logic       bubble_mem,
    output logic       div_busy
);

    localparam logic [2:0] WSEL_RAM = 3'b011;
    localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE,
        DIV_BUSY
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;

    logic       ex_v_q, ex_v_d;
    logic       ex_we_q, ex_we_d;
    logic [4:0] ex_waddr_q, ex_waddr_d;
    logic [2:0] ex_wsel_q, ex_wsel_d;

    logic       mem_v_q, mem_v_d;
    logic       mem_we_q, mem_we_d;
    logic [4:0] mem_waddr_q, mem_waddr_d;
    logic [2:0] mem_wsel_q, mem_wsel_d;

    logic rs_read, rt_read;
    logic ex_rs_match, ex_rt_match;
    logic mem_rs_match, mem_rt_match;
    logic ex_is_load, mem_is_load;
    logic lu;

    // Register 0 is hard-wired, so it never matches even when a write targets it.
    always_comb begin
        rs_read      = id_valid & id_use_rs;
        rt_read      = id_valid & id_use_rt;
        ex_rs_match  = rs_read & ex_v_q & ex_we_q & (ex_waddr_q == id_rs) & (id_rs != 5'd0);
        ex_rt_match  = rt_read & ex_v_q & ex_we_q & (ex_waddr_q == id_rt) & (id_rt != 5'd0);
        mem_rs_match = rs_read & mem_v_q & mem_we_q & (mem_waddr_q == id_rs) & (id_rs != 5'd0);
        mem_rt_match = rt_read & mem_v_q & mem_we_q & (mem_waddr_q == id_rt) & (id_rt != 5'd0);
        ex_is_load   = (ex_wsel_q == WSEL_RAM);
        mem_is_load  = (mem_wsel_q == WSEL_RAM);
    end

    // EX results shadow older MEM results for the same register.
    always_comb begin
        id_ex_hazard_mem     = (ex_rs_match | ex_rt_match) & ex_is_load;
        id_ex_rs_hazard_reg  = ex_rs_match & ~ex_is_load;
        id_ex_rt_hazard_reg  = ex_rt_match & ~ex_is_load;
        id_mem_rs_hazard_mem = ~ex_rs_match & mem_rs_match & mem_is_load;
        id_mem_rs_hazard_reg = ~ex_rs_match & mem_rs_match & ~mem_is_load;
        id_mem_rt_hazard_mem = ~ex_rt_match & mem_rt_match & mem_is_load;
        id_mem_rt_hazard_reg = ~ex_rt_match & mem_rt_match & ~mem_is_load;
        ex_rf_wsel           = ex_v_q ? ex_wsel_q : 3'b000;
        mem_rf_wsel          = mem_v_q ? mem_wsel_q : 3'b000;
    end

    always_comb begin
        div_busy   = (state_q == DIV_BUSY);
        lu         = id_ex_hazard_mem & ~div_busy;
        stall_if   = div_busy | lu;
        bubble_ex  = lu;
        stall_ex   = div_busy;
        bubble_mem = div_busy;
    end

    // A running divide freezes EX and drains MEM; otherwise the records shift,
    // with a bubble replacing the ID instruction on a load-use stall.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ex_v_d      = ex_v_q;
        ex_we_d     = ex_we_q;
        ex_waddr_d  = ex_waddr_q;
        ex_wsel_d   = ex_wsel_q;
        mem_v_d     = mem_v_q;
        mem_we_d    = mem_we_q;
        mem_waddr_d = mem_waddr_q;
        mem_wsel_d  = mem_wsel_q;
        case (state_q)
            DIV_BUSY: begin
                mem_v_d = 1'b0;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                mem_v_d     = ex_v_q;
                mem_we_d    = ex_we_q;
                mem_waddr_d = ex_waddr_q;
                mem_wsel_d  = ex_wsel_q;
                if (lu) begin
                    ex_v_d = 1'b0;
                end else begin
                    ex_v_d     = id_valid;
                    ex_we_d    = id_rf_we;
                    ex_waddr_d = id_rf_waddr;
                    ex_wsel_d  = id_rf_wsel;
                    if (id_valid && id_is_div) begin
                        state_d = DIV_BUSY;
                        cnt_d   = DIV_LOAD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            ex_v_q      <= 1'b0;
            ex_we_q     <= 1'b0;
            ex_waddr_q  <= 5'd0;
            ex_wsel_q   <= 3'b000;
            mem_v_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= 5'd0;
            mem_wsel_q  <= 3'b000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ex_v_q      <= ex_v_d;
            ex_we_q     <= ex_we_d;
            ex_waddr_q  <= ex_waddr_d;
            ex_wsel_q   <= ex_wsel_d;
            mem_v_q     <= mem_v_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wsel_q  <= mem_wsel_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with DIV_CYCLES=4; every expected value is hand-derived.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       id_valid, id_use_rs, id_use_rt, id_rf_we, id_is_div;
    logic [4:0] id_rs, id_rt, id_rf_waddr;
    logic [2:0] id_rf_wsel;
    logic       id_ex_hazard_mem, id_ex_rs_hazard_reg, id_ex_rt_hazard_reg;
    logic       id_mem_rs_hazard_mem, id_mem_rs_hazard_reg;
    logic       id_mem_rt_hazard_mem, id_mem_rt_hazard_reg;
    logic [2:0] ex_rf_wsel, mem_rf_wsel;
    logic       stall_if, bubble_ex, stall_ex, bubble_mem, div_busy;

    int checkCount = 0;
    int failCount  = 0;

    logic [6:0] flags;
    logic [4:0] ctrl;

    hazard_ctrl #(.DIV_CYCLES(4)) dut (
        .clk(clk),
        .resetn(resetn),
        .id_valid(id_valid),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt),
        .id_rf_we(id_rf_we),
        .id_rf_waddr(id_rf_waddr),
        .id_rf_wsel(id_rf_wsel),
        .id_is_div(id_is_div),
        .id_ex_hazard_mem(id_ex_hazard_mem),
        .id_ex_rs_hazard_reg(id_ex_rs_hazard_reg),
        .id_ex_rt_hazard_reg(id_ex_rt_hazard_reg),
        .id_mem_rs_hazard_mem(id_mem_rs_hazard_mem),
        .id_mem_rs_hazard_reg(id_mem_rs_hazard_reg),
        .id_mem_rt_hazard_mem(id_mem_rt_hazard_mem),
        .id_mem_rt_hazard_reg(id_mem_rt_hazard_reg),
        .ex_rf_wsel(ex_rf_wsel),
        .mem_rf_wsel(mem_rf_wsel),
        .stall_if(stall_if),
        .bubble_ex(bubble_ex),
        .stall_ex(stall_ex),
        .bubble_mem(bubble_mem),
        .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    // flags: {ex_mem, ex_rs_reg, ex_rt_reg, mem_rs_mem, mem_rs_reg, mem_rt_mem, mem_rt_reg}
    // ctrl:  {stall_if, bubble_ex, stall_ex, bubble_mem, div_busy}
    assign flags = {id_ex_hazard_mem, id_ex_rs_hazard_reg, id_ex_rt_hazard_reg,
                    id_mem_rs_hazard_mem, id_mem_rs_hazard_reg,
                    id_mem_rt_hazard_mem, id_mem_rt_hazard_reg};
    assign ctrl  = {stall_if, bubble_ex, stall_ex, bubble_mem, div_busy};

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [6:0] expFlags, input logic [4:0] expCtrl,
                              input logic [2:0] expExWsel, input logic [2:0] expMemWsel);
        checkOutput({tag, "_flags"}, 32'(flags), 32'(expFlags));
        checkOutput({tag, "_ctrl"}, 32'(ctrl), 32'(expCtrl));
        checkOutput({tag, "_exwsel"}, 32'(ex_rf_wsel), 32'(expExWsel));
        checkOutput({tag, "_memwsel"}, 32'(mem_rf_wsel), 32'(expMemWsel));
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt, input logic we,
                                 input logic [4:0] waddr, input logic [2:0] wsel, input logic isDiv);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_rf_we    = we;
        id_rf_waddr = waddr;
        id_rf_wsel  = wsel;
        id_is_div   = isDiv;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] hazard_ctrl directed test, DIV_CYCLES=4");
        resetn = 1'b0;
        applyStimulus(1, 5, 5, 1, 1, 1, 5, 3'b001, 0);
        repeat (2) @(posedge clk);
        #4 checkState("in_reset", 7'b0, 5'b0, 3'd0, 3'd0);

        nextCycle(); resetn = 1'b1;
        applyStimulus(1, 5, 0, 1, 0, 0, 5, 3'b000, 0);
        #3 checkState("released", 7'b0, 5'b0, 3'd0, 3'd0);

        // ALU forwarding from EX, then from MEM
        nextCycle(); applyStimulus(1, 1, 2, 1, 1, 1, 3, 3'b001, 0);
        #3 checkState("addu_r3", 7'b0, 5'b0, 3'd0, 3'd0);
        nextCycle(); applyStimulus(1, 3, 3, 1, 1, 0, 0, 3'b000, 0);
        #3 checkState("beq_ex_fwd", 7'b0110000, 5'b0, 3'd1, 3'd0);
        nextCycle(); applyStimulus(1, 3, 7, 1, 1, 0, 0, 3'b000, 0);
        #3 checkState("mem_fwd", 7'b0000100, 5'b0, 3'd0, 3'd1);

        // Load-use: one stall cycle, then the load is seen in MEM
        nextCycle(); applyStimulus(1, 1, 0, 1, 0, 1, 4, 3'b011, 0);
        #3 checkState("lw_r4", 7'b0, 5'b0, 3'd0, 3'd0);
        nextCycle(); applyStimulus(1, 4, 0, 1, 1, 1, 5, 3'b001, 0);
        #3 checkState("load_use", 7'b1000000, 5'b11000, 3'd3, 3'd0);
        nextCycle();
        #3 checkState("after_lu", 7'b0001000, 5'b0, 3'd0, 3'd3);

        // EX over MEM priority and r0 immunity
        nextCycle(); applyStimulus(1, 1, 0, 1, 0, 1, 6, 3'b001, 0);
        #3 checkState("ori_r6", 7'b0, 5'b0, 3'd1, 3'd0);
        nextCycle(); applyStimulus(1, 2, 0, 1, 1, 1, 6, 3'b001, 0);
        #3 checkState("addu_r6", 7'b0, 5'b0, 3'd1, 3'd1);
        nextCycle(); applyStimulus(1, 6, 6, 1, 0, 1, 0, 3'b001, 0);
        #3 checkState("priority", 7'b0100000, 5'b0, 3'd1, 3'd1);
        nextCycle(); applyStimulus(1, 0, 0, 1, 1, 0, 0, 3'b001, 0);
        #3 checkState("read_r0", 7'b0, 5'b0, 3'd1, 3'd1);

        // Divide: three busy cycles, then one idle cycle while it leaves EX
        nextCycle(); applyStimulus(1, 8, 9, 1, 1, 0, 0, 3'b100, 1);
        #3 checkState("div_in_id", 7'b0, 5'b0, 3'd1, 3'd1);
        nextCycle(); applyStimulus(1, 11, 0, 1, 0, 1, 10, 3'b011, 0);
        #3 checkState("div_busy1", 7'b0, 5'b10111, 3'd4, 3'd1);
        nextCycle();
        #3 checkState("div_busy2", 7'b0, 5'b10111, 3'd4, 3'd0);
        nextCycle();
        #3 checkState("div_busy3", 7'b0, 5'b10111, 3'd4, 3'd0);
        nextCycle();
        #3 checkState("div_leave", 7'b0, 5'b0, 3'd4, 3'd0);
        nextCycle(); applyStimulus(1, 10, 0, 1, 0, 1, 11, 3'b001, 0);
        #3 checkState("lu_after_div", 7'b1000000, 5'b11000, 3'd3, 3'd4);

        // Back-to-back divides, then reset in the middle of the second
        nextCycle(); applyStimulus(1, 12, 13, 1, 1, 0, 0, 3'b101, 1);
        #3 checkState("diva_in_id", 7'b0, 5'b0, 3'd0, 3'd3);
        nextCycle(); applyStimulus(1, 14, 15, 1, 1, 0, 0, 3'b100, 1);
        #3 checkState("diva_busy1", 7'b0, 5'b10111, 3'd5, 3'd0);
        nextCycle();
        #3 checkState("diva_busy2", 7'b0, 5'b10111, 3'd5, 3'd0);
        nextCycle();
        #3 checkState("diva_busy3", 7'b0, 5'b10111, 3'd5, 3'd0);
        nextCycle();
        #3 checkState("diva_leave", 7'b0, 5'b0, 3'd5, 3'd0);
        nextCycle(); applyStimulus(1, 1, 2, 1, 1, 1, 7, 3'b001, 0);
        #3 checkState("divb_busy1", 7'b0, 5'b10111, 3'd4, 3'd5);
        nextCycle();
        #3 checkState("divb_busy2", 7'b0, 5'b10111, 3'd4, 3'd0);
        #1 resetn = 1'b0;
        #1 checkState("reset_mid_div", 7'b0, 5'b0, 3'd0, 3'd0);
        nextCycle(); resetn = 1'b1;
        #3 checkState("post_reset", 7'b0, 5'b0, 3'd0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
